// File: rtl/audio_frame_header_parser_if.sv
// Bus between the audio bitstream shifter/decoder side and the MPEG-1 audio frame header parser.
// The master side drives the bitstream window and control pulses; the parser is the slave.
interface audio_frame_header_parser_if #(
    parameter int BAD_CNT_WIDTH = 8
);
    logic                     Start_I;
    logic                     Abort_I;
    logic                     Next_I;
    logic                     Buffer_Empty_I;
    logic                     Audio_Shift_Busy_I;
    logic                     Audio_Byte_Allign_I;
    logic [15:0]              Audio_Data_I;
    logic [4:0]               Audio_Shift_En_O;
    logic                     Parser_Busy_O;
    logic                     Header_Valid_O;
    logic [19:0]              Header_O;
    logic [15:0]              CRC_O;
    logic [10:0]              Frame_Bytes_O;
    logic [BAD_CNT_WIDTH-1:0] Bad_Header_Count_O;

    modport master (
        output Start_I, Abort_I, Next_I, Buffer_Empty_I, Audio_Shift_Busy_I,
               Audio_Byte_Allign_I, Audio_Data_I,
        input  Audio_Shift_En_O, Parser_Busy_O, Header_Valid_O, Header_O, CRC_O,
               Frame_Bytes_O, Bad_Header_Count_O
    );

    modport slave (
        input  Start_I, Abort_I, Next_I, Buffer_Empty_I, Audio_Shift_Busy_I,
               Audio_Byte_Allign_I, Audio_Data_I,
        output Audio_Shift_En_O, Parser_Busy_O, Header_Valid_O, Header_O, CRC_O,
               Frame_Bytes_O, Bad_Header_Count_O
    );
endinterface

// File: rtl/audio_frame_header_parser.sv
// MPEG-1 audio syncword search and 32-bit header capture/validation driving the bitstream shifter.
// Optional macro AUDIO_HDR_FRAMELEN_EN adds the Layer II frame length table (Frame_Bytes_O).
module audio_frame_header_parser #(
    parameter int SETTLE_CYCLES = 1,
    parameter int BAD_CNT_WIDTH = 8
) (
    input logic                        clock,
    input logic                        reset,
    audio_frame_header_parser_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ALIGN  = 3'd1;
    localparam logic [2:0] ST_SEARCH = 3'd2;
    localparam logic [2:0] ST_CAP0   = 3'd3;
    localparam logic [2:0] ST_CAP1   = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_CRC    = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    localparam int                    SETTLE_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [BAD_CNT_WIDTH-1:0] BAD_MAX  = {BAD_CNT_WIDTH{1'b1}};

    logic [2:0]               state_reg;
    logic [SETTLE_W-1:0]      settle_reg;
    logic [1:0]               pending_reg;
    logic [1:0]               shift_en_reg;
    logic [19:0]              hdr_reg;
    logic [15:0]              crc_reg;
    logic [19:0]              header_out_reg;
    logic [15:0]              crc_out_reg;
    logic [10:0]              frame_calc_reg;
    logic [10:0]              frame_out_reg;
    logic [BAD_CNT_WIDTH-1:0] bad_cnt_reg;

    logic        settled;
    logic        shift_ok;
    logic        sync_found;
    logic        hdr_invalid;
    logic [10:0] frame_len;

    // The window is only trusted once the shifter has had time to react to the last pulse.
    assign settled     = (settle_reg == '0);
    assign shift_ok    = settled && !bus.Audio_Shift_Busy_I && !bus.Buffer_Empty_I;
    assign sync_found  = (bus.Audio_Data_I[15:4] == 12'hFFF);
    assign hdr_invalid = (hdr_reg[18:17] == 2'b00) || (hdr_reg[15:12] == 4'hF) ||
                         (hdr_reg[11:10] == 2'b11);

`ifdef AUDIO_HDR_FRAMELEN_EN
    localparam int KBPS  [14] = '{32, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 384};
    localparam int FS_HZ [3]  = '{44100, 48000, 32000};

    logic [10:0] len_rom [42];
    logic [5:0]  rom_idx;

    // Lengths are elaboration-time constants: bitrate-major, sampling-frequency-minor.
    for (genvar gi = 0; gi < 42; gi++) begin : g_len_rom
        localparam int LEN = (144 * KBPS[gi / 3] * 1000) / FS_HZ[gi % 3];
        assign len_rom[gi] = 11'(LEN);
    end

    always_comb begin
        rom_idx   = 6'd0;
        frame_len = 11'd0;
        if (hdr_reg[19] && hdr_reg[18:17] == 2'b10 && hdr_reg[15:12] != 4'h0 &&
            hdr_reg[15:12] != 4'hF && hdr_reg[11:10] != 2'b11) begin
            rom_idx   = ({2'b00, hdr_reg[15:12]} - 6'd1) * 6'd3 + {4'b0000, hdr_reg[11:10]};
            frame_len = len_rom[rom_idx] + {10'd0, hdr_reg[9]};
        end
    end
`else
    assign frame_len = 11'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            settle_reg     <= '0;
            pending_reg    <= 2'd0;
            shift_en_reg   <= 2'b00;
            hdr_reg        <= 20'd0;
            crc_reg        <= 16'd0;
            header_out_reg <= 20'd0;
            crc_out_reg    <= 16'd0;
            frame_calc_reg <= 11'd0;
            frame_out_reg  <= 11'd0;
            bad_cnt_reg    <= '0;
        end else if (bus.Abort_I) begin
            state_reg      <= ST_IDLE;
            settle_reg     <= '0;
            pending_reg    <= 2'd0;
            shift_en_reg   <= 2'b00;
            hdr_reg        <= 20'd0;
            crc_reg        <= 16'd0;
            header_out_reg <= 20'd0;
            crc_out_reg    <= 16'd0;
            frame_calc_reg <= 11'd0;
            frame_out_reg  <= 11'd0;
        end else begin
            shift_en_reg <= 2'b00;
            if (!settled) settle_reg <= settle_reg - 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (bus.Start_I) state_reg <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (settled && bus.Audio_Byte_Allign_I) begin
                        state_reg <= ST_SEARCH;
                    end else if (shift_ok) begin
                        shift_en_reg <= 2'b01;
                        settle_reg   <= SETTLE_LOAD;
                    end
                end
                ST_SEARCH: begin
                    if (settled && sync_found) begin
                        state_reg   <= ST_CAP0;
                        pending_reg <= 2'd2;
                    end else if (shift_ok) begin
                        shift_en_reg <= 2'b10;
                        settle_reg   <= SETTLE_LOAD;
                    end
                end
                ST_CAP0, ST_CAP1, ST_CRC: begin
                    // Window is unchanged until the first of the two byte shifts is issued.
                    if (pending_reg == 2'd2) begin
                        if (state_reg == ST_CAP0)      hdr_reg[19:16] <= bus.Audio_Data_I[3:0];
                        else if (state_reg == ST_CAP1) hdr_reg[15:0]  <= bus.Audio_Data_I;
                        else                           crc_reg        <= bus.Audio_Data_I;
                    end
                    if (pending_reg != 2'd0) begin
                        if (shift_ok) begin
                            shift_en_reg <= 2'b10;
                            settle_reg   <= SETTLE_LOAD;
                            pending_reg  <= pending_reg - 2'd1;
                        end
                    end else if (settled) begin
                        if (state_reg == ST_CAP0) begin
                            state_reg   <= ST_CAP1;
                            pending_reg <= 2'd2;
                        end else if (state_reg == ST_CAP1) begin
                            state_reg <= ST_CHECK;
                        end else begin
                            state_reg      <= ST_DONE;
                            header_out_reg <= hdr_reg;
                            crc_out_reg    <= crc_reg;
                            frame_out_reg  <= frame_calc_reg;
                        end
                    end
                end
                ST_CHECK: begin
                    frame_calc_reg <= frame_len;
                    if (hdr_invalid) begin
                        if (bad_cnt_reg != BAD_MAX) bad_cnt_reg <= bad_cnt_reg + 1'b1;
                        state_reg <= ST_SEARCH;
                    end else if (!hdr_reg[16]) begin
                        state_reg   <= ST_CRC;
                        pending_reg <= 2'd2;
                    end else begin
                        state_reg      <= ST_DONE;
                        header_out_reg <= hdr_reg;
                        crc_out_reg    <= 16'd0;
                        frame_out_reg  <= frame_len;
                    end
                end
                ST_DONE: begin
                    if (bus.Next_I) state_reg <= ST_SEARCH;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.Audio_Shift_En_O   = {3'b000, shift_en_reg};
    assign bus.Parser_Busy_O      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign bus.Header_Valid_O     = (state_reg == ST_DONE);
    assign bus.Header_O           = header_out_reg;
    assign bus.CRC_O              = crc_out_reg;
    assign bus.Frame_Bytes_O      = frame_out_reg;
    assign bus.Bad_Header_Count_O = bad_cnt_reg;
endmodule

// File: tb/tb_audio_frame_header_parser.sv
// Directed bench for audio_frame_header_parser: a byte-array bitstream shifter model feeds the
// parser, and hand-computed header/CRC/length/counter values are checked after each scenario.
module tb_audio_frame_header_parser;
    localparam int MEM_BYTES = 2048;
`ifdef AUDIO_HDR_FRAMELEN_EN
    localparam int FB_192_48  = 576;
    localparam int FB_128_441 = 418;
    localparam int FB_160_48  = 480;
`else
    localparam int FB_192_48  = 0;
    localparam int FB_128_441 = 0;
    localparam int FB_160_48  = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_frame_header_parser_if #(.BAD_CNT_WIDTH(8)) bus ();

    audio_frame_header_parser #(.SETTLE_CYCLES(1), .BAD_CNT_WIDTH(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Shifter model
    logic [7:0]  mem [MEM_BYTES];
    int          ptr = 0;
    int          nptr;
    int          ptr_set = 0;
    bit          ptr_req = 1'b0;
    bit          cnt_clr = 1'b0;
    logic [15:0] data_q = 16'd0;
    logic        align_q = 1'b1;
    int          cnt1 = 0;
    int          cnt8 = 0;
    int          cnt1_at_first8 = -1;
    int          bad_pulse = 0;
    logic        prev_pulse = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] window(int p);
        logic [15:0] w;
        int b;
        w = 16'd0;
        for (int i = 0; i < 16; i++) begin
            b = p + i;
            if (b / 8 < MEM_BYTES) w[15-i] = mem[b / 8][7 - (b % 8)];
        end
        return w;
    endfunction

    always_comb begin
        nptr = ptr;
        if (ptr_req) nptr = ptr_set;
        else nptr = ptr + (bus.Audio_Shift_En_O[0] ? 1 : 0) + (bus.Audio_Shift_En_O[1] ? 8 : 0);
    end

    always @(posedge clk) begin
        ptr     <= nptr;
        data_q  <= window(nptr);
        align_q <= (nptr % 8 == 0);
        prev_pulse <= |bus.Audio_Shift_En_O;
        if (cnt_clr) begin
            cnt1           <= 0;
            cnt8           <= 0;
            cnt1_at_first8 <= -1;
            bad_pulse      <= 0;
        end else begin
            if (bus.Audio_Shift_En_O[0]) cnt1 <= cnt1 + 1;
            if (bus.Audio_Shift_En_O[1]) begin
                cnt8 <= cnt8 + 1;
                if (cnt8 == 0) cnt1_at_first8 <= cnt1;
            end
            if ((|bus.Audio_Shift_En_O && prev_pulse) || (&bus.Audio_Shift_En_O[1:0]) ||
                (|bus.Audio_Shift_En_O[4:2]))
                bad_pulse <= bad_pulse + 1;
        end
    end

    assign bus.Audio_Data_I        = data_q;
    assign bus.Audio_Byte_Allign_I = align_q;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    endtask

    task automatic put_hdr(input int addr, input logic [31:0] h);
        mem[addr]     = h[31:24];
        mem[addr + 1] = h[23:16];
        mem[addr + 2] = h[15:8];
        mem[addr + 3] = h[7:0];
    endtask

    task automatic abort_load(input int p);
        bus.Abort_I = 1'b1;
        ptr_set     = p;
        ptr_req     = 1'b1;
        cnt_clr     = 1'b1;
        tick(1);
        bus.Abort_I = 1'b0;
        ptr_req     = 1'b0;
        cnt_clr     = 1'b0;
    endtask

    task automatic start_pulse();
        bus.Start_I = 1'b1;
        tick(1);
        bus.Start_I = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!bus.Header_Valid_O && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, bus.Header_Valid_O}, 32'd1);
    endtask

    task automatic wait_cnt8(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (cnt8 < target && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, cnt8, target);
    endtask

    int snap;

    initial begin
        bus.Start_I            = 1'b0;
        bus.Abort_I            = 1'b0;
        bus.Next_I             = 1'b0;
        bus.Buffer_Empty_I     = 1'b0;
        bus.Audio_Shift_Busy_I = 1'b0;
        clear_mem();

        // Reset state
        rst = 1'b1;
        tick(3);
        check("rst_shift_en", {27'd0, bus.Audio_Shift_En_O}, 32'd0);
        check("rst_busy",     {31'd0, bus.Parser_Busy_O}, 32'd0);
        check("rst_valid",    {31'd0, bus.Header_Valid_O}, 32'd0);
        check("rst_header",   {12'd0, bus.Header_O}, 32'd0);
        check("rst_bad_cnt",  {24'd0, bus.Bad_Header_Count_O}, 32'd0);
        rst = 1'b0;
        tick(1);

        // 1: 00 FF FD A4 00 -> Layer II, unprotected, 192k, 48k
        clear_mem();
        mem[0] = 8'h00;
        put_hdr(1, 32'hFFFD_A400);
        abort_load(0);
        start_pulse();
        check("t1_busy_after_start", {31'd0, bus.Parser_Busy_O}, 32'd1);
        wait_valid("t1_valid", 300);
        check("t1_header",   {12'd0, bus.Header_O}, 32'h000DA400);
        check("t1_crc",      {16'd0, bus.CRC_O}, 32'd0);
        check("t1_frame",    {21'd0, bus.Frame_Bytes_O}, FB_192_48);
        check("t1_bad_cnt",  {24'd0, bus.Bad_Header_Count_O}, 32'd0);
        check("t1_done_busy", {31'd0, bus.Parser_Busy_O}, 32'd0);
        tick(2);
        check("t1_done_shift_en", {27'd0, bus.Audio_Shift_En_O}, 32'd0);
        bus.Next_I = 1'b1;
        tick(1);
        bus.Next_I = 1'b0;
        check("t1_valid_after_next",  {31'd0, bus.Header_Valid_O}, 32'd0);
        check("t1_header_hold",       {12'd0, bus.Header_O}, 32'h000DA400);

        // 2: protected Layer II 128k 44.1k padded, CRC 1234
        clear_mem();
        put_hdr(0, 32'hFFFC_8200);
        mem[4] = 8'h12;
        mem[5] = 8'h34;
        abort_load(0);
        check("t2_abort_clears_header", {12'd0, bus.Header_O}, 32'd0);
        start_pulse();
        wait_valid("t2_valid", 300);
        check("t2_header", {12'd0, bus.Header_O}, 32'h000C8200);
        check("t2_crc",    {16'd0, bus.CRC_O}, 32'h00001234);
        check("t2_frame",  {21'd0, bus.Frame_Bytes_O}, FB_128_441);

        // 3: bad bitrate header, then a valid one
        clear_mem();
        put_hdr(0, 32'hFFFD_F400);
        put_hdr(4, 32'hFFFD_A400);
        abort_load(0);
        start_pulse();
        wait_valid("t3_valid", 400);
        check("t3_bad_cnt", {24'd0, bus.Bad_Header_Count_O}, 32'd1);
        check("t3_header",  {12'd0, bus.Header_O}, 32'h000DA400);

        // 4: start at bit offset 3; then stall the shifter for 10 cycles mid-search
        clear_mem();
        put_hdr(40, 32'hFFFD_9400);
        abort_load(3);
        start_pulse();
        wait_cnt8("t4_first_shift8", 1, 200);
        check("t4_shift1_before_shift8", cnt1_at_first8, 32'd5);
        bus.Audio_Shift_Busy_I = 1'b1;
        tick(1);
        snap = cnt1 + cnt8;
        tick(10);
        check("t4_no_pulse_while_busy", cnt1 + cnt8, snap);
        bus.Audio_Shift_Busy_I = 1'b0;
        wait_valid("t4_valid", 500);
        check("t4_header",      {12'd0, bus.Header_O}, 32'h000D9400);
        check("t4_frame",       {21'd0, bus.Frame_Bytes_O}, FB_160_48);
        check("t4_total_shift1", cnt1, 32'd5);
        check("t4_pulse_rules",  bad_pulse, 32'd0);

        // 5: abort while in CAP1 (shifter stalled after the two CAP0 byte shifts)
        clear_mem();
        put_hdr(0, 32'hFFFD_A400);
        abort_load(0);
        start_pulse();
        wait_cnt8("t5_cap0_shifts", 2, 200);
        bus.Audio_Shift_Busy_I = 1'b1;
        tick(3);
        check("t5_busy_in_cap1", {31'd0, bus.Parser_Busy_O}, 32'd1);
        bus.Abort_I = 1'b1;
        tick(1);
        bus.Abort_I = 1'b0;
        bus.Audio_Shift_Busy_I = 1'b0;
        check("t5_abort_busy",     {31'd0, bus.Parser_Busy_O}, 32'd0);
        check("t5_abort_valid",    {31'd0, bus.Header_Valid_O}, 32'd0);
        check("t5_abort_shift_en", {27'd0, bus.Audio_Shift_En_O}, 32'd0);
        tick(5);
        check("t5_idle_no_shift", cnt8, 32'd2);
        check("t5_bad_cnt_kept",  {24'd0, bus.Bad_Header_Count_O}, 32'd1);

        // 6: reset clears counter; 257 bad headers saturate it
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("t6_rst_bad_cnt", {24'd0, bus.Bad_Header_Count_O}, 32'd0);
        clear_mem();
        for (int i = 0; i < 257; i++) put_hdr(i * 4, 32'hFFFD_F400);
        put_hdr(257 * 4, 32'hFFFD_A400);
        abort_load(0);
        start_pulse();
        wait_valid("t6_valid", 20000);
        check("t6_bad_cnt_sat", {24'd0, bus.Bad_Header_Count_O}, 32'h000000FF);
        check("t6_header",      {12'd0, bus.Header_O}, 32'h000DA400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
